// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with valid/ack handshakes toward instruction ROM and
// data memory. One instruction retires per FETCH..commit walk; a taken jump to
// its own PC parks the core in HALT until reset.
module hack_cpu_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_n,
  output logic                  o_Instr_Req,
  output logic [ADDR_WIDTH-1:0] o_PC,
  input  logic                  i_Instr_Valid,
  input  logic [DATA_WIDTH-1:0] i_Instruction,
  output logic                  o_Mem_Rd,
  output logic                  o_Mem_Wr,
  output logic [ADDR_WIDTH-1:0] o_Address_Mem,
  output logic [DATA_WIDTH-1:0] o_Mem,
  input  logic                  i_Mem_Ack,
  input  logic [DATA_WIDTH-1:0] i_Mem,
  output logic                  o_Retire,
  output logic                  o_Halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg;
  logic [DATA_WIDTH-1:0]   a_reg, d_reg, ir_reg, m_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;
  logic                    retire_reg;

  logic [DATA_WIDTH-1:0]   x_val, y_val, alu_out;
  logic                    is_c, zr, ng, taken, halt_hit, commit;
  logic [ADDR_WIDTH-1:0]   jump_target, pc_inc;

  assign is_c        = ir_reg[DATA_WIDTH-1];
  assign jump_target = a_reg[ADDR_WIDTH-1:0];
  assign pc_inc      = pc_reg + PC_ONE;

  // Hack ALU: X is always D, Y is old A or the fetched M operand
  always_comb begin
    x_val = d_reg;
    y_val = ir_reg[12] ? m_reg : a_reg;
    if (ir_reg[11]) x_val = '0;
    if (ir_reg[10]) x_val = ~x_val;
    if (ir_reg[9])  y_val = '0;
    if (ir_reg[8])  y_val = ~y_val;
    alu_out = ir_reg[7] ? (x_val + y_val) : (x_val & y_val);
    if (ir_reg[6])  alu_out = ~alu_out;
  end

  assign zr       = (alu_out == '0);
  assign ng       = alu_out[DATA_WIDTH-1];
  assign taken    = is_c & ((ir_reg[2] & ng) | (ir_reg[1] & zr) | (ir_reg[0] & ~zr & ~ng));
  assign halt_hit = taken & (jump_target == pc_reg);

  // Next-state logic; commit marks the single edge that updates architectural state
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (i_Instr_Valid) begin
          if (i_Instruction[DATA_WIDTH-1] && i_Instruction[12]) state_next = READ;
          else                                                  state_next = EXEC;
        end
      end
      READ:  if (i_Mem_Ack) state_next = EXEC;
      EXEC: begin
        if (is_c && ir_reg[3]) begin
          state_next = WRITE;
        end else begin
          commit     = 1'b1;
          state_next = halt_hit ? HALT : FETCH;
        end
      end
      WRITE: begin
        if (i_Mem_Ack) begin
          commit     = 1'b1;
          state_next = halt_hit ? HALT : FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Datapath: operand capture during the walk, architectural update only on commit
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      pc_reg      <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      ir_reg      <= '0;
      m_reg       <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      retire_reg  <= 1'b0;
    end else begin
      retire_reg <= commit;
      if (state_reg == FETCH && i_Instr_Valid) ir_reg <= i_Instruction;
      if (state_reg == READ && i_Mem_Ack)      m_reg  <= i_Mem;
      if (state_reg == EXEC && is_c && ir_reg[3]) begin
        wr_addr_reg <= a_reg[ADDR_WIDTH-1:0];
        wr_data_reg <= alu_out;
      end
      if (commit) begin
        if (!is_c) begin
          a_reg <= {1'b0, ir_reg[DATA_WIDTH-2:0]};
        end else begin
          if (ir_reg[5]) a_reg <= alu_out;
          if (ir_reg[4]) d_reg <= alu_out;
        end
        pc_reg <= taken ? jump_target : pc_inc;
      end
    end
  end

  assign o_Instr_Req   = (state_reg == FETCH);
  assign o_Mem_Rd      = (state_reg == READ);
  assign o_Mem_Wr      = (state_reg == WRITE);
  assign o_Halted      = (state_reg == HALT);
  assign o_PC          = pc_reg;
  assign o_Address_Mem = (state_reg == WRITE) ? wr_addr_reg : a_reg[ADDR_WIDTH-1:0];
  assign o_Mem         = wr_data_reg;
  assign o_Retire      = retire_reg;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: table of single C-instructions, hand sequences for the
// multi-cycle corners, and random programs checked against an ISA-level model.
module tb_hack_cpu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_Instr_Req, o_Mem_Rd, o_Mem_Wr, o_Retire, o_Halted;
  logic [14:0] o_PC, o_Address_Mem;
  logic        i_Instr_Valid, i_Mem_Ack;
  logic [15:0] i_Instruction, i_Mem, o_Mem;

  // small-address instance for PC wrap
  logic        s_req, s_rd, s_wr, s_retire, s_halted;
  logic [3:0]  s_pc, s_addr;
  logic        s_valid, s_ack;
  logic [15:0] s_instr, s_mem_in, s_mem_out;

  always #5 clk = ~clk;

  hack_cpu_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) dut (
    .i_CLK(clk), .i_RESET_n(rst_n),
    .o_Instr_Req(o_Instr_Req), .o_PC(o_PC),
    .i_Instr_Valid(i_Instr_Valid), .i_Instruction(i_Instruction),
    .o_Mem_Rd(o_Mem_Rd), .o_Mem_Wr(o_Mem_Wr),
    .o_Address_Mem(o_Address_Mem), .o_Mem(o_Mem),
    .i_Mem_Ack(i_Mem_Ack), .i_Mem(i_Mem),
    .o_Retire(o_Retire), .o_Halted(o_Halted));

  hack_cpu_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_small (
    .i_CLK(clk), .i_RESET_n(rst_n),
    .o_Instr_Req(s_req), .o_PC(s_pc),
    .i_Instr_Valid(s_valid), .i_Instruction(s_instr),
    .o_Mem_Rd(s_rd), .o_Mem_Wr(s_wr),
    .o_Address_Mem(s_addr), .o_Mem(s_mem_out),
    .i_Mem_Ack(s_ack), .i_Mem(s_mem_in),
    .o_Retire(s_retire), .o_Halted(s_halted));

  logic [15:0] rom [256];
  logic [15:0] ram [256];
  logic [15:0] mram [256];
  int  rom_wait, rd_wait, wr_wait, fcnt, mcnt;
  bit  rand_mode;
  int  retire_cnt, wr_count, base_ret, base_wr, wr_len;
  bit  wr_stable;
  logic [14:0] last_wr_addr, wr_addr0;
  logic [15:0] last_wr_data, wr_data0;
  int  n_vec, n_bad;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] aval;
    logic [15:0] dval;
    logic [15:0] mval;
    logic [15:0] exp_data;
    logic [14:0] exp_pc;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // memory-side responder, evaluated once per negedge
  task respond();
    bit go;
    if (o_Retire) retire_cnt++;
    if (o_Instr_Req) begin
      go = rand_mode ? 1'($urandom_range(0, 1)) : (fcnt >= rom_wait);
      i_Instr_Valid = go;
      i_Instruction = go ? rom[o_PC[7:0]] : 16'($urandom);
      fcnt = go ? 0 : fcnt + 1;
    end else begin
      fcnt = 0;
      i_Instr_Valid = rand_mode & 1'($urandom_range(0, 1));
      i_Instruction = 16'($urandom);
    end
    if (o_Mem_Rd) begin
      go = rand_mode ? 1'($urandom_range(0, 1)) : (mcnt >= rd_wait);
      i_Mem_Ack = go;
      i_Mem = go ? ram[o_Address_Mem[7:0]] : 16'($urandom);
      mcnt = go ? 0 : mcnt + 1;
    end else if (o_Mem_Wr) begin
      if (mcnt == 0) begin
        wr_addr0 = o_Address_Mem; wr_data0 = o_Mem; wr_stable = 1'b1; wr_len = 0;
      end
      wr_len++;
      if (o_Address_Mem !== wr_addr0 || o_Mem !== wr_data0) wr_stable = 1'b0;
      go = rand_mode ? 1'($urandom_range(0, 1)) : (mcnt >= wr_wait);
      i_Mem_Ack = go;
      if (go) begin
        ram[o_Address_Mem[7:0]] = o_Mem;
        last_wr_addr = o_Address_Mem; last_wr_data = o_Mem;
        wr_count++;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
      i_Mem_Ack = rand_mode & 1'($urandom_range(0, 1));
      i_Mem = 16'($urandom);
    end
  endtask

  task tick();
    @(negedge clk);
    respond();
    #1;
  endtask

  task do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    base_ret = retire_cnt;
    base_wr  = wr_count;
  endtask

  task wait_ret(input int n, input string name, output bit ok);
    int k;
    k = 0;
    while ((retire_cnt - base_ret) < n && k < 400) begin
      tick();
      k++;
    end
    ok = ((retire_cnt - base_ret) >= n);
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: retired %0d, want %0d", name, retire_cnt - base_ret, n);
    end
  endtask

  task clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  initial begin
    bit ok, tk, halted_m, wr_exp;
    int k, sn, reqs, wr_before;
    logic [15:0] ins, ma, md, xv, yv, ov;
    logic [14:0] mpc, npc;

    vt[0] = '{16'hE088, 16'd10, 16'd5,  16'd0,   16'h000F, 15'd4};   // M=D+A
    vt[1] = '{16'hFDC8, 16'd7,  16'd0,  16'd41,  16'h002A, 15'd4};   // M=M+1
    vt[2] = '{16'hE4C8, 16'd5,  16'd3,  16'd0,   16'hFFFE, 15'd4};   // M=D-A
    vt[3] = '{16'hE008, 16'd10, 16'd12, 16'd0,   16'h0008, 15'd4};   // M=D&A
    vt[4] = '{16'hE34C, 16'd20, 16'd0,  16'd0,   16'hFFFF, 15'd20};  // M=!D;JLT taken
    vt[5] = '{16'hE30A, 16'd9,  16'd0,  16'd0,   16'h0000, 15'd9};   // M=D;JEQ taken
    vt[6] = '{16'hE309, 16'd9,  16'd0,  16'd0,   16'h0000, 15'd4};   // M=D;JGT not taken
    vt[7] = '{16'hEE88, 16'd2,  16'd7,  16'd0,   16'hFFFF, 15'd4};   // M=-1
    vt[8] = '{16'hFCAF, 16'd30, 16'd1,  16'd100, 16'h0063, 15'd30};  // AM=M-1;JMP old A
    vt[9] = '{16'hF548, 16'd3,  16'd5,  16'd10,  16'h000F, 15'd4};   // M=D|M

    n_vec = 0; n_bad = 0; retire_cnt = 0; wr_count = 0; base_ret = 0; base_wr = 0;
    rst_n = 1'b0; rand_mode = 1'b0; rom_wait = 0; rd_wait = 0; wr_wait = 0;
    fcnt = 0; mcnt = 0; wr_len = 0; wr_stable = 1'b0;
    i_Instr_Valid = 1'b0; i_Instruction = '0; i_Mem_Ack = 1'b0; i_Mem = '0;
    s_valid = 1'b1; s_instr = 16'h0000; s_ack = 1'b0; s_mem_in = '0;
    last_wr_addr = '0; last_wr_data = '0; wr_addr0 = '0; wr_data0 = '0;
    clear_mem();

    // reset values, then @5 / D=A with zero wait states
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE308;
    tick(); rst_n = 1'b0; tick(); tick();
    chk("reset_outputs", {27'd0, o_Instr_Req, o_Mem_Rd, o_Mem_Wr, o_Retire, o_Halted}, 32'd0);
    chk("reset_pc", o_PC, 32'd0);
    rst_n = 1'b1; base_ret = retire_cnt; base_wr = wr_count;
    repeat (5) tick();
    chk("t1_retires", retire_cnt - base_ret, 32'd2);
    chk("t1_pc", o_PC, 32'd2);
    wait_ret(4, "t1", ok);
    chk("t1_d_addr", last_wr_addr, 32'd100);
    chk("t1_d_data", last_wr_data, 32'd5);
    $display("seq t1: D=A then M=D wrote %04h at %0d", last_wr_data, last_wr_addr);

    // single-instruction table
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      rom[0] = vt[v].dval; rom[1] = 16'hEC10; rom[2] = vt[v].aval; rom[3] = vt[v].instr;
      ram[vt[v].aval[7:0]] = vt[v].mval;
      do_reset();
      wait_ret(4, "vec", ok);
      chk("vec_wr_count", wr_count - base_wr, 32'd1);
      chk("vec_wr_addr", last_wr_addr, {17'd0, vt[v].aval[14:0]});
      chk("vec_wr_data", last_wr_data, {16'd0, vt[v].exp_data});
      chk("vec_pc", o_PC, {17'd0, vt[v].exp_pc});
      $display("vec %0d instr %04h wrote %04h at %0d pc %0d", v, vt[v].instr, last_wr_data,
               last_wr_addr, o_PC);
    end

    // M=M+1 with read and write wait states
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hFDC8; ram[7] = 16'd41;
    rd_wait = 3; wr_wait = 2;
    do_reset();
    wait_ret(2, "t2", ok);
    chk("t2_ram", ram[7], 32'd42);
    chk("t2_wr_len", wr_len, 32'd3);
    chk("t2_wr_stable", wr_stable, 32'd1);
    rd_wait = 0; wr_wait = 0;
    $display("seq t2: RAM[7]=%0d, write held %0d cycles", ram[7], wr_len);

    // D=-1;JLT taken, D=0;JLT not taken
    clear_mem();
    rom[0] = 16'h0003; rom[1] = 16'hEE94; rom[3] = 16'hEA94;
    do_reset();
    wait_ret(2, "t3a", ok);
    chk("t3_jlt_taken", o_PC, 32'd3);
    wait_ret(3, "t3b", ok);
    chk("t3_jlt_fall", o_PC, 32'd4);
    $display("seq t3: pc after jumps %0d", o_PC);

    // AM=M+1 writes old A, A takes the result
    clear_mem();
    rom[0] = 16'h000A; rom[1] = 16'hFDE8; rom[2] = 16'hEC10; rom[3] = 16'h0032; rom[4] = 16'hE308;
    ram[10] = 16'd20;
    do_reset();
    wait_ret(2, "t4a", ok);
    chk("t4_am_addr", last_wr_addr, 32'd10);
    chk("t4_am_data", last_wr_data, 32'd21);
    wait_ret(5, "t4b", ok);
    chk("t4_a_addr", last_wr_addr, 32'd50);
    chk("t4_a_value", last_wr_data, 32'd21);
    $display("seq t4: A after AM=M+1 is %0d", last_wr_data);

    // PC wrap on a 4-bit address core running @0 forever
    do_reset();
    sn = 0;
    for (k = 0; k < 200 && sn < 16; k++) begin
      tick();
      if (s_retire) begin
        sn++;
        if (sn == 15) chk("t5_pc15", s_pc, 32'd15);
        if (sn == 16) chk("t5_wrap", s_pc, 32'd0);
      end
    end
    chk("t5_retires", sn, 32'd16);
    $display("seq t5: small core pc %0d after %0d retires", s_pc, sn);

    // self-loop halt
    clear_mem();
    rom[3] = 16'h0004; rom[4] = 16'hEA87;
    do_reset();
    wait_ret(5, "t6", ok);
    chk("t6_halted", o_Halted, 32'd1);
    chk("t6_pc", o_PC, 32'd4);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      reqs += int'(o_Instr_Req | o_Mem_Rd | o_Mem_Wr);
    end
    chk("t6_no_requests", reqs, 32'd0);
    chk("t6_still_halted", o_Halted, 32'd1);
    chk("t6_retires", retire_cnt - base_ret, 32'd5);
    $display("seq t6: halted=%0d at pc %0d", o_Halted, o_PC);

    // reset in the middle of a write wait
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hE308; ram[7] = 16'd55;
    wr_wait = 1000;
    do_reset();
    k = 0;
    while (!o_Mem_Wr && k < 50) begin tick(); k++; end
    chk("t7_wr_seen", o_Mem_Wr, 32'd1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t7_wr_dropped", o_Mem_Wr, 32'd0);
    chk("t7_ram", ram[7], 32'd55);
    chk("t7_pc", o_PC, 32'd0);
    wr_wait = 0;
    $display("seq t7: mem_wr=%0d RAM[7]=%0d pc=%0d", o_Mem_Wr, ram[7], o_PC);

    // random programs against the ISA model
    for (int it = 0; it < 4; it++) begin
      rand_mode = 1'b1;
      for (int i = 0; i < 256; i++) begin
        rom[i] = ($urandom_range(0, 2) == 0) ? {1'b0, 15'($urandom)} : {3'b111, 13'($urandom)};
        ram[i] = 16'($urandom);
        mram[i] = ram[i];
      end
      ma = '0; md = '0; mpc = '0; halted_m = 1'b0;
      do_reset();
      for (int r = 1; r <= 150 && !halted_m; r++) begin
        wr_before = wr_count;
        wait_ret(r, "rand", ok);
        if (!ok) break;
        ins = rom[mpc[7:0]];
        wr_exp = 1'b0;
        if (!ins[15]) begin
          ma  = {1'b0, ins[14:0]};
          npc = mpc + 15'd1;
        end else begin
          xv = ins[11] ? 16'd0 : md;
          if (ins[10]) xv = ~xv;
          yv = ins[9] ? 16'd0 : (ins[12] ? mram[ma[7:0]] : ma);
          if (ins[8]) yv = ~yv;
          ov = ins[7] ? xv + yv : xv & yv;
          if (ins[6]) ov = ~ov;
          tk = (ins[2] && $signed(ov) < 0) || (ins[1] && ov == 16'd0) || (ins[0] && $signed(ov) > 0);
          if (ins[3]) begin
            mram[ma[7:0]] = ov;
            wr_exp = 1'b1;
          end
          npc = tk ? ma[14:0] : mpc + 15'd1;
          halted_m = tk && (ma[14:0] == mpc);
          if (wr_exp) begin
            chk("rand_wr_addr", last_wr_addr, {17'd0, ma[14:0]});
            chk("rand_wr_data", last_wr_data, {16'd0, ov});
          end
          if (ins[5]) ma = ov;
          if (ins[4]) md = ov;
        end
        chk("rand_wr_count", wr_count - wr_before, {31'd0, wr_exp});
        chk("rand_pc", o_PC, {17'd0, npc});
        chk("rand_halt", o_Halted, {31'd0, halted_m});
        mpc = npc;
      end
      $display("rand prog %0d: %0d retires, pc %0d, halted %0d", it, retire_cnt - base_ret,
               o_PC, o_Halted);
    end
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
